// File: rtl/regfile_pkg.sv
// Shared types for the burst register file: controller state encoding and entry parity helper.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_WR = 2'd1,
        BURST_RD = 2'd2
    } state_t;

    localparam int unsigned PAR_MAX_W = 64;

    // Even-parity bit; callers zero-extend narrower words, which leaves the XOR unchanged
    function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_burst_ctrl.sv
// Request-port controller: single/burst command decode, burst pointer and beat counter.
module regfile_burst_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              req_ready,
    output logic              busy,
    output logic              wr_en_c,
    output logic              rd_en_c,
    output logic [ADDR_W-1:0] addr_c
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [ADDR_W-1:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            req_ready <= (state_n != BURST_RD);
            busy      <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        wr_en_c = 1'b0;
        rd_en_c = 1'b0;
        addr_c  = ptr;
        case (state)
            IDLE: begin
                addr_c = req_addr;
                if (req_valid) begin
                    wr_en_c = req_wr;
                    rd_en_c = !req_wr;
                    // The command beat is also the first data beat of a burst
                    if (req_burst) begin
                        ptr_n = req_addr + ADDR_W'(1);
                        cnt_n = req_len;
                        if (req_len != '0) begin
                            state_n = req_wr ? BURST_WR : BURST_RD;
                        end
                    end
                end
            end
            BURST_WR: begin
                if (req_valid) begin
                    wr_en_c = 1'b1;
                    ptr_n   = ptr + ADDR_W'(1);
                    cnt_n   = cnt - ADDR_W'(1);
                    if (cnt == ADDR_W'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            BURST_RD: begin
                rd_en_c = 1'b1;
                ptr_n   = ptr + ADDR_W'(1);
                cnt_n   = cnt - ADDR_W'(1);
                if (cnt == ADDR_W'(1)) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/regfile_burst.sv
// Parametrised register file with single/burst access and a flat snapshot for the hash core.
// Optional REGFILE_PARITY_EN adds per-entry even parity, rsp_perr and the inj_perr test hook.
module regfile_burst
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wr,
    input  logic                     req_burst,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [ADDR_W-1:0]        req_len,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
`ifdef REGFILE_PARITY_EN
    input  logic                     inj_perr,
    output logic                     rsp_perr,
`endif
    output logic [DATA_W*DEPTH-1:0]  flat_out
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] addr_c;

    regfile_burst_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_burst (req_burst),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .busy      (busy),
        .wr_en_c   (wr_en_c),
        .rd_en_c   (rd_en_c),
        .addr_c    (addr_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_c) begin
            mem[addr_c] <= wdata;
        end
    end

    // Registered read port; data forced to zero when no read was issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_en_c;
            rsp_data  <= rd_en_c ? mem[addr_c] : '0;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                par[i] <= 1'b0;
            end
            rsp_perr <= 1'b0;
        end else begin
            if (wr_en_c) begin
                par[addr_c] <= parity(PAR_MAX_W'(wdata)) ^ inj_perr;
            end
            rsp_perr <= rd_en_c && (par[addr_c] != parity(PAR_MAX_W'(mem[addr_c])));
        end
    end
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign flat_out[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: doc/regfile_burst.md
Name: regfile_burst

Overview:
- Parametrised successor to the SHA message/state byte register file.
- Depth and word width are configurable.
- Accesses go through a valid/ready request port with registered read data.
- Adds an auto-incrementing burst mode for loading or unloading a whole block (e.g. a 64-byte SHA message) with one command.
- A flat snapshot of all entries is kept for the hash core.
- Sits between the host/SRAM loader and the SHA round logic.

Parameters:
DATA_W, 8, entry width in bits
DEPTH, 32, number of entries (power of two, >=2)
ADDR_W, $clog2(DEPTH), address width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  command/beat valid
req_ready  out  1  command/beat accepted when valid&&ready
req_wr  in  1  1=write, 0=read (sampled at command accept)
req_burst  in  1  1=burst command (sampled at command accept)
req_addr  in  ADDR_W  start address
req_len  in  ADDR_W  burst beats minus one (ignored when req_burst=0)
wdata  in  DATA_W  write data; sampled on every accepted write beat
rsp_valid  out  1  read data valid, one cycle after read beat
rsp_data  out  DATA_W  read data; 0 when rsp_valid=0
busy  out  1  burst in progress
flat_out  out  DATA_W*DEPTH  entry i on bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (rst=1 at clk edge):
  - All entries cleared to 0.
  - FSM goes to IDLE; ptr and cnt cleared.
  - rsp_valid=0, rsp_data=0, busy=0.
  - Reset overrides any in-flight burst; a burst aborted by reset leaves no pending response.
- FSM states: IDLE, BURST_WR, BURST_RD.
- IDLE:
  - req_ready=1.
  - Single write: the accepted beat writes wdata to entry req_addr; visible on flat_out the next cycle.
  - Single read: rsp_valid=1 and rsp_data=mem[req_addr] the next cycle (latency 1).
  - Burst accept:
    - The first beat is also the command beat.
    - A write burst writes wdata to req_addr on the accept cycle.
    - A read burst issues a read of req_addr on the accept cycle.
    - ptr<=req_addr+1 (mod DEPTH) and cnt<=req_len.
    - If req_len=0 the FSM stays in IDLE, so the command behaves as a single access.
    - Otherwise the FSM goes to BURST_WR or BURST_RD and busy=1.
- BURST_WR:
  - req_ready=1.
  - Each cycle with req_valid=1 writes wdata to mem[ptr], increments ptr and decrements cnt.
  - Cycles with req_valid=0 stall; no write occurs.
  - req_wr, req_burst and req_addr are ignored during the burst.
  - The beat taken with cnt=1 is the last; IDLE follows.
- BURST_RD:
  - req_ready=0.
  - The block reads mem[ptr] every cycle without stalling; no backpressure on rsp.
  - rsp_valid is high for exactly req_len+1 consecutive cycles, counting the command-accept read.
  - Returns to IDLE after the last read is issued.
  - The next command is accepted in the cycle after the last read issue, while the final rsp is still being presented.
- Address wrap: ptr increments modulo DEPTH (DEPTH-1 -> 0). A burst longer than DEPTH is impossible because req_len < DEPTH.
- Read-during-write to the same entry (single access only; the port is exclusive) is not possible.
- rsp_data returns the stored value before any write in the same cycle; no such write exists by construction.
- flat_out is driven directly from storage, with no extra latency beyond the write edge.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- With the macro:
  - Each entry stores an extra even-parity bit, computed on write; it resets to 0, which is consistent with zero data.
  - Added output rsp_perr (1 bit), asserted together with rsp_valid when the stored parity mismatches the stored data.
  - Added input inj_perr (1 bit): when high on an accepted write beat, the stored parity bit is inverted (test hook).
- Without the macro: no parity storage and no rsp_perr/inj_perr ports.

Decomposition:
- Package regfile_pkg: state enum type (IDLE/BURST_WR/BURST_RD) and a parity function over DATA_W.
- One natural sub-module, regfile_burst_ctrl: FSM, ptr/cnt and handshake. Storage and flat_out stay in the top.

Test Plan:
- Reset then idle read of addr 5 -> rsp_valid=1 one cycle later, rsp_data=0x00; flat_out all zero.
- Single write 0xA5 to addr 3, then read addr 3 -> rsp_data=0xA5 exactly 1 cycle after the read accept; flat_out[31:24]=0xA5.
- Write burst at addr 30, req_len=3, data 0x11,0x22,0x33,0x44 with one req_valid=0 stall cycle mid-burst:
  - Entries 30,31,0,1 = 0x11,0x22,0x33,0x44.
  - busy falls after the 4th beat.
- Read burst at addr 30, req_len=3 -> req_ready=0 for 3 cycles; rsp_valid high 4 consecutive cycles with 0x11,0x22,0x33,0x44.
- rst asserted during the 2nd beat of a read burst (req_len=7) -> next cycle: busy=0, rsp_valid=0, all entries 0, req_ready=1.
- REGFILE_PARITY_EN: write 0x01 with inj_perr=1 at addr 7, then read addr 7 -> rsp_perr=1. Rewrite without inj_perr and read -> rsp_perr=0.
